// File: rtl/serial_pkg.sv
// serial_pkg: frame format constants and state encoding shared by the serial transmitter and receiver.
package serial_pkg;

    localparam int PRE_LEN   = 2;
    localparam int DATA_BITS = 8;
    localparam int PRE_W     = $clog2(PRE_LEN);
    localparam int IDX_W     = $clog2(DATA_BITS);

    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        START,
        DATA,
        GUARD
    } frame_state_e;

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous DEPTH x WIDTH FIFO with first-word-fall-through output and wrap-bit pointers.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp_q, rp_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // A pop frees its slot at the same edge, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = wp_q == rp_q;
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout    = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: queues bytes and serialises each as preamble, start, eight data bits LSB first and a guard cycle.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 load,
    output logic                 ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 sent
);

    frame_state_e         state_q, state_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, fifo_dout;
    logic                 txd_q, txd_d, sent_q, sent_d;
    logic                 pop, full, empty;

    tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (load),
        .pop   (pop),
        .din   (data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign ready = !full && !rst;
    assign busy  = !empty || (state_q != IDLE);
    assign txd   = txd_q;
    assign sent  = sent_q;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE, GUARD: begin
                pop     = !empty;
                pre_d   = '0;
                shift_d = empty ? shift_q : fifo_dout;
                state_d = empty ? IDLE : PRE;
            end
            PRE: begin
                pre_d   = pre_q + 1'b1;
                state_d = (pre_q == PRE_W'(PRE_LEN - 1)) ? START : PRE;
            end
            START: begin
                idx_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == IDX_W'(DATA_BITS - 1)) ? GUARD : DATA;
            end
            default: state_d = IDLE;
        endcase
        // Line level is derived from the next state so txd stays a clean register output.
        txd_d  = (state_d == DATA) ? shift_d[0] : (state_d == PRE) ? ~LINE_IDLE : LINE_IDLE;
        sent_d = state_d == GUARD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= LINE_IDLE;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            sent_q  <= sent_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed stimulus for serial_tx with a frame-decoding monitor checked against an expected-byte queue.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, txd, busy, sent;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    serial_tx #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .load  (load),
        .ready (ready),
        .txd   (txd),
        .busy  (busy),
        .sent  (sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 8'(busy), 8'd0);
        @(negedge clk);
    endtask

    // Monitor: decodes frames off txd like the receiver would and scores them against exp_q.
    int         mph = 0;
    int         nb = 0;
    logic       p1 = 1'b1;
    logic       p2 = 1'b1;
    logic [7:0] sh = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            mph = 0;
            p1  = 1'b1;
            p2  = 1'b1;
        end else begin
            if (mph == 2) begin
                check("guard_txd", 8'(txd), 8'd1);
                check("guard_sent", 8'(sent), 8'd1);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL frame_byte: got %02h expected no frame at %0t", sh, $time);
                end else begin
                    check("frame_byte", sh, exp_q.pop_front());
                end
                mph = 0;
            end else begin
                check("sent_off", 8'(sent), 8'd0);
                if (mph == 1) begin
                    sh[nb] = txd;
                    nb++;
                    if (nb == 8) mph = 2;
                end else if (!p2 && !p1 && txd) begin
                    mph = 1;
                    nb  = 0;
                end
            end
            p2 = p1;
            p1 = txd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:11] tv;
        int          n;
        tv = 12'b001101001011;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", 8'(txd), 8'd1);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_sent", 8'(sent), 8'd0);
        check("rst_ready", 8'(ready), 8'd0);
        #1 rst = 1'b0;
        #1 check("post_rst_ready", 8'(ready), 8'd1);
        @(negedge clk);

        // Single byte 0xA5
        exp_q.push_back(8'hA5);
        #1 data = 8'hA5;
        load = 1'b1;
        @(negedge clk);
        #1 load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("a5_txd", 8'(txd), 8'(tv[k-1]));
            check("a5_sent", 8'(sent), 8'(k == 12));
        end
        @(negedge clk);
        check("a5_busy_c13", 8'(busy), 8'd0);
        @(negedge clk);

        // Back-to-back 0x00, 0xFF, 0x3C
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        #1 data = 8'h00;
        load = 1'b1;
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            if (c >= 1) check("b2b_sent", 8'(sent), 8'(c % 12 == 0));
            if (c % 12 == 1) check("b2b_pre", 8'(txd), 8'd0);
            if (c % 12 == 3) check("b2b_start", 8'(txd), 8'd1);
            if (c == 0) #1 data = 8'hFF;
            if (c == 1) #1 data = 8'h3C;
            if (c == 2) #1 load = 1'b0;
        end
        @(negedge clk);
        check("b2b_busy_c37", 8'(busy), 8'd0);
        @(negedge clk);

        // Overflow, then simultaneous push/pop while full
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h77);
        #1 data = 8'h01;
        load = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            if (c <= 5) check("ovf_ready", 8'(ready), 8'(c < 4));
            if (c == 12) check("ovf_sent", 8'(sent), 8'd1);
            if (c == 13) check("pushpop_ready", 8'(ready), 8'd0);
            if (c == 24) check("full_ready", 8'(ready), 8'd0);
            if (c == 25) check("reassert_ready", 8'(ready), 8'd1);
            if (c < 5) #1 data = 8'(c + 2);
            if (c == 5) #1 load = 1'b0;
            if (c == 12) begin
                #1 data = 8'h77;
                load = 1'b1;
            end
            if (c == 13) #1 load = 1'b0;
        end
        wait_idle();

        // Reset in the middle of the data bits
        #1 data = 8'h5A;
        load = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 0) #1 load = 1'b0;
            if (c == 6) check("mid_d2", 8'(txd), 8'd0);
            if (c == 7) begin
                check("mid_d3", 8'(txd), 8'd1);
                #1 rst = 1'b1;
                #1 check("mid_rst_ready", 8'(ready), 8'd0);
            end
            if (c == 8) begin
                check("mid_txd", 8'(txd), 8'd1);
                check("mid_busy", 8'(busy), 8'd0);
                check("mid_sent", 8'(sent), 8'd0);
                #1 rst = 1'b0;
                #1 check("mid_ready", 8'(ready), 8'd1);
            end
        end
        @(negedge clk);
        exp_q.push_back(8'hC3);
        #1 data = 8'hC3;
        load = 1'b1;
        @(negedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        wait_idle();

        // Loopback sweep 0x00..0xFF
        for (int v = 0; v < 256; v++) begin
            n = 0;
            while (!ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("lb_ready", 8'(ready), 8'd1);
            exp_q.push_back(8'(v));
            #1 data = 8'(v);
            load = 1'b1;
            @(negedge clk);
            #1 load = 1'b0;
        end
        @(negedge clk);
        wait_idle();

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
